// File: rtl/wb_pkg.sv
// Shared constants, load-type encodings and grant-source enum for the writeback unit.
package wb_pkg;

  localparam int XLEN         = 32;
  localparam int NREGS        = 32;
  localparam int AW           = $clog2(NREGS);
  localparam int STARVE_LIMIT = 2;
  localparam int CW           = $clog2(STARVE_LIMIT + 1);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } grant_src_e;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load data formatter: extracts byte/half/word from the aligned memory word,
// applies sign/zero extension and flags misaligned or unsupported load types.
module load_formatter
  import wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{byte_off, 3'b000} +: 8];
    sel_half = word[{byte_off[1], 4'b0000} +: 16];
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      LD_LB:  data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LD_LBU: data = {{(XLEN-8){1'b0}}, sel_byte};
      LD_LH: begin
        data     = {{(XLEN-16){sel_half[15]}}, sel_half};
        misalign = byte_off[0];
      end
      LD_LHU: begin
        data     = {{(XLEN-16){1'b0}}, sel_half};
        misalign = byte_off[0];
      end
      LD_LW: begin
        data     = word;
        misalign = |byte_off;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write front end: arbitrates ALU and load results onto one registered write port.
// Optional pending-destination scoreboard is enabled by defining WB_SCOREBOARD_EN.
module writeback_unit
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_byte_off,
  input  logic [XLEN-1:0] ld_word,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_data,
  output logic            ld_misalign,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   query_rs1,
  input  logic [AW-1:0]   query_rs2,
  output logic            busy_rs1,
  output logic            busy_rs2
);

  grant_src_e      grant;
  logic [CW-1:0]   starve_cnt;
  logic [XLEN-1:0] ld_data;
  logic            ld_bad;
  logic            wb_commit;

  load_formatter u_fmt (
    .funct3   (ld_funct3),
    .byte_off (ld_byte_off),
    .word     (ld_word),
    .data     (ld_data),
    .misalign (ld_bad)
  );

  // Loads win contention until the ALU has waited STARVE_LIMIT load grants; nothing is taken in reset.
  always_comb begin
    grant = SRC_NONE;
    if (!reset) begin
      if (ld_valid && !(alu_valid && (starve_cnt == CW'(STARVE_LIMIT))))
        grant = SRC_LD;
      else if (alu_valid)
        grant = SRC_ALU;
    end
  end

  assign alu_ready = (grant == SRC_ALU);
  assign ld_ready  = (grant == SRC_LD);

  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if ((grant == SRC_LD) && alu_valid)
      starve_cnt <= starve_cnt + 1'b1;
    else
      starve_cnt <= '0;
  end

  // wb_commit marks every accepted result, including suppressed x0 and misaligned writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      ld_misalign <= 1'b0;
      wb_commit   <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      ld_misalign <= 1'b0;
      wb_commit   <= 1'b0;
      case (grant)
        SRC_ALU: begin
          rf_we     <= (alu_rd != '0);
          rf_addr   <= alu_rd;
          rf_data   <= alu_data;
          wb_commit <= 1'b1;
        end
        SRC_LD: begin
          rf_we       <= (ld_rd != '0) && !ld_bad;
          rf_addr     <= ld_rd;
          rf_data     <= ld_data;
          ld_misalign <= ld_bad;
          wb_commit   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [NREGS-1:0] pending;

  // The issue set is applied after the commit clear so a same-register collision stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wb_commit)
        pending[rf_addr] <= 1'b0;
      if (issue_valid && (issue_rd != '0))
        pending[issue_rd] <= 1'b1;
    end
  end

  assign busy_rs1 = pending[query_rs1];
  assign busy_rs2 = pending[query_rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rd, query_rs1, query_rs2, wb_commit};
  assign busy_rs1  = 1'b0;
  assign busy_rs2  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors push expected writes, a negedge monitor
// pops and compares whenever the DUT presents a write or misalign pulse.
module tb_writeback_unit;
  import wb_pkg::*;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            mis;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_byte_off;
  logic [XLEN-1:0] ld_word;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XLEN-1:0] rf_data;
  logic            ld_misalign;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   query_rs1;
  logic [AW-1:0]   query_rs2;
  logic            busy_rs1;
  logic            busy_rs2;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  logic sb_exp;

  writeback_unit dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_funct3   (ld_funct3),
    .ld_byte_off (ld_byte_off),
    .ld_word     (ld_word),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .ld_misalign (ld_misalign),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic we, input logic [AW-1:0] addr,
                              input logic [XLEN-1:0] data, input logic mis);
    exp_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    e.mis  = mis;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive, check readies before the edge, queue the expected write.
  task automatic apply_stimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                                input logic lv, input logic [AW-1:0] lrd, input logic [2:0] f3,
                                input logic [1:0] off, input logic [XLEN-1:0] word,
                                input logic exp_ar, input logic exp_lr,
                                input logic do_push, input exp_t e);
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = adat;
    ld_valid    = lv;
    ld_rd       = lrd;
    ld_funct3   = f3;
    ld_byte_off = off;
    ld_word     = word;
    #2;
    check_output("alu_ready", alu_ready, exp_ar);
    check_output("ld_ready", ld_ready, exp_lr);
    if (do_push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 3'b000, 2'b00, '0, 1'b0, 1'b0, 1'b0, mk(1'b0, '0, '0, 1'b0));
  endtask

  task automatic load(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [1:0] off,
                      input logic [XLEN-1:0] word, input exp_t e);
    apply_stimulus(1'b0, '0, '0, 1'b1, rd, f3, off, word, 1'b0, 1'b1, 1'b1, e);
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1 || ld_misalign === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got we=%0b addr=%0d data=0x%08h mis=%0b expected none",
                 rf_we, rf_addr, rf_data, ld_misalign);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("wb_we", rf_we, mon_e.we);
        check_output("wb_misalign", ld_misalign, mon_e.mis);
        check_output("wb_addr", rf_addr, mon_e.addr);
        if (mon_e.we) check_output("wb_data", rf_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef WB_SCOREBOARD_EN
    sb_exp = 1'b1;
`else
    sb_exp = 1'b0;
`endif
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_byte_off = '0; ld_word = '0;
    issue_valid = 1'b0; issue_rd = '0; query_rs1 = '0; query_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_rf_we", rf_we, 1'b0);
    check_output("reset_rf_addr", rf_addr, 32'd0);
    check_output("reset_rf_data", rf_data, 32'd0);
    check_output("reset_misalign", ld_misalign, 1'b0);
    reset = 1'b0;

    $display("[TB] ALU only");
    apply_stimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, 3'b000, 2'b00, '0, 1'b1, 1'b0, 1'b1,
                   mk(1'b1, 5'd5, 32'h1234, 1'b0));
    idle();
    check_output("alu_pulse_we", rf_we, 1'b0);
    check_output("alu_hold_addr", rf_addr, 32'd5);
    check_output("alu_hold_data", rf_data, 32'h1234);

    $display("[TB] load formats");
    load(5'd10, LD_LB,  2'd3, 32'h80FF7F01, mk(1'b1, 5'd10, 32'hFFFFFF80, 1'b0));
    load(5'd11, LD_LBU, 2'd1, 32'h80FF7F01, mk(1'b1, 5'd11, 32'h0000007F, 1'b0));
    load(5'd12, LD_LH,  2'd2, 32'h80FF7F01, mk(1'b1, 5'd12, 32'hFFFF80FF, 1'b0));
    load(5'd13, LD_LHU, 2'd0, 32'h80FF7F01, mk(1'b1, 5'd13, 32'h00007F01, 1'b0));
    load(5'd14, LD_LW,  2'd0, 32'h80FF7F01, mk(1'b1, 5'd14, 32'h80FF7F01, 1'b0));
    idle();

    $display("[TB] contention");
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, LD_LW, 2'd0, 32'h11111111, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd2, 32'h11111111, 1'b0));
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd3, LD_LW, 2'd0, 32'h22222222, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd3, 32'h22222222, 1'b0));
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd4, LD_LW, 2'd0, 32'h33333333, 1'b1, 1'b0, 1'b1,
                   mk(1'b1, 5'd1, 32'hAAAA0001, 1'b0));
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0002, 1'b1, 5'd4, LD_LW, 2'd0, 32'h33333333, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd4, 32'h33333333, 1'b0));
    idle();

    $display("[TB] x0 and misaligned");
    apply_stimulus(1'b1, 5'd0, 32'h0000DEAD, 1'b0, '0, 3'b000, 2'b00, '0, 1'b1, 1'b0, 1'b0,
                   mk(1'b0, '0, '0, 1'b0));
    check_output("x0_no_write", rf_we, 1'b0);
    check_output("x0_no_misalign", ld_misalign, 1'b0);
    load(5'd7, LD_LW, 2'd2, 32'h12345678, mk(1'b0, 5'd7, '0, 1'b1));
    check_output("misalign_pulse", ld_misalign, 1'b1);
    idle();
    check_output("misalign_clear", ld_misalign, 1'b0);
    load(5'd8, 3'b011, 2'd0, 32'h12345678, mk(1'b0, 5'd8, '0, 1'b1));
    idle();

    $display("[TB] scoreboard");
    query_rs1 = 5'd9;
    query_rs2 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    idle();
    issue_valid = 1'b0;
    check_output("busy_after_issue_rs1", busy_rs1, sb_exp);
    check_output("busy_after_issue_rs2", busy_rs2, sb_exp);
    load(5'd9, LD_LW, 2'd0, 32'h00000099, mk(1'b1, 5'd9, 32'h00000099, 1'b0));
    check_output("busy_through_write", busy_rs1, sb_exp);
    idle();
    check_output("busy_cleared", busy_rs1, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd9;
    idle();
    issue_valid = 1'b0;
    check_output("busy_reissue", busy_rs1, sb_exp);
    load(5'd9, LD_LW, 2'd0, 32'h00000999, mk(1'b1, 5'd9, 32'h00000999, 1'b0));
    issue_valid = 1'b1; issue_rd = 5'd9;
    idle();
    issue_valid = 1'b0;
    check_output("busy_set_wins", busy_rs1, sb_exp);
    idle();
    check_output("busy_set_wins_hold", busy_rs2, sb_exp);
    issue_valid = 1'b1; issue_rd = 5'd0;
    query_rs1 = 5'd0;
    idle();
    issue_valid = 1'b0;
    check_output("x0_never_busy", busy_rs1, 1'b0);

    $display("[TB] reset after transfer");
    issue_valid = 1'b1; issue_rd = 5'd12;
    idle();
    issue_valid = 1'b0;
    query_rs1 = 5'd12;
    query_rs2 = 5'd9;
    check_output("busy_pre_reset", busy_rs1, sb_exp);
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0003, 1'b1, 5'd6, LD_LW, 2'd0, 32'h00000066, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd6, 32'h00000066, 1'b0));
    reset = 1'b1;
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0003, 1'b1, 5'd2, LD_LW, 2'd0, 32'h11111111, 1'b0, 1'b0, 1'b0,
                   mk(1'b0, '0, '0, 1'b0));
    check_output("rst_rf_we", rf_we, 1'b0);
    check_output("rst_rf_addr", rf_addr, 32'd0);
    check_output("rst_rf_data", rf_data, 32'd0);
    check_output("rst_busy_rs1", busy_rs1, 1'b0);
    check_output("rst_busy_rs2", busy_rs2, 1'b0);
    reset = 1'b0;
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0003, 1'b1, 5'd2, LD_LW, 2'd0, 32'h11111111, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd2, 32'h11111111, 1'b0));
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0003, 1'b1, 5'd3, LD_LW, 2'd0, 32'h22222222, 1'b0, 1'b1, 1'b1,
                   mk(1'b1, 5'd3, 32'h22222222, 1'b0));
    apply_stimulus(1'b1, 5'd1, 32'hAAAA0003, 1'b1, 5'd4, LD_LW, 2'd0, 32'h33333333, 1'b1, 1'b0, 1'b1,
                   mk(1'b1, 5'd1, 32'hAAAA0003, 1'b0));
    idle();
    idle();
    check_output("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
